// File: rtl/final_adder.sv
// final_adder: pipelined carry-propagate adder that resolves a redundant
// sum/carry vector pair into a binary product. The carry chain is cut into
// SEG segments of WIDTH/SEG bits, one register stage per segment, with a
// valid/ready handshake (global stall) and an opaque tag carried alongside.
//
// Optional feature: define FINAL_ADDER_OVF_CHECK_EN to capture the carry
// out of the full-width addition into out_err. Without it out_err is a
// constant 0 and the last-stage carry register does not exist.

// One carry-chain segment plus its pipeline register.
module final_adder_stage #(
    parameter int WIDTH  = 8,
    parameter int SW     = 4,
    parameter int LO     = 0,
    parameter int TAG_W  = 4,
    parameter bit CY_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_prod,
    input  logic             i_cy,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_prod,
    output logic             o_cy,
    output logic [TAG_W-1:0] o_tag
);
    logic [SW:0]      w_seg;
    logic [WIDTH-1:0] w_prod_nx;
    logic             r_vld;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_prod;
    logic [TAG_W-1:0] r_tag;

    // Segment addition: this stage's slice of both operands plus carry-in.
    assign w_seg = {1'b0, i_a[LO +: SW]} + {1'b0, i_b[LO +: SW]} + {{SW{1'b0}}, i_cy};

    // Merge the freshly resolved slice into the partial product.
    always_comb begin
        w_prod_nx            = i_prod;
        w_prod_nx[LO +: SW]  = w_seg[SW-1:0];
    end

    // Stage register: holds on stall, otherwise advances (bubbles included).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_tag  <= '0;
        end else if (!i_stall) begin
            r_vld  <= i_vld;
            r_a    <= i_a;
            r_b    <= i_b;
            r_prod <= w_prod_nx;
            r_tag  <= i_tag;
        end
    end

    generate
        if (CY_REG) begin : g_cy
            logic r_cy;

            // Carry out of the segment's top bit, consumed by the next stage
            // (or reported as overflow when this is the last stage).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_cy <= 1'b0;
                else if (!i_stall)
                    r_cy <= w_seg[SW];
            end
            assign o_cy = r_cy;
        end else begin : g_no_cy
            logic w_unused_cy;
            assign w_unused_cy = w_seg[SW];
            assign o_cy        = 1'b0;
        end
    endgenerate

    assign o_vld  = r_vld;
    assign o_a    = r_a;
    assign o_b    = r_b;
    assign o_prod = r_prod;
    assign o_tag  = r_tag;
endmodule

// Top level: SEG chained segment stages driven by a single global stall.
module final_adder #(
    parameter int WIDTH = 8,
    parameter int SEG   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int SW = WIDTH / SEG;
`ifdef FINAL_ADDER_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    generate
        if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_cfg
            $error("final_adder: WIDTH must be a multiple of SEG");
        end
    endgenerate

    // Index k feeds stage k; index k+1 is stage k's registered output.
    logic [SEG:0]             w_vld;
    logic [SEG:0][WIDTH-1:0]  w_a;
    logic [SEG:0][WIDTH-1:0]  w_b;
    logic [SEG:0][WIDTH-1:0]  w_prod;
    logic [SEG:0]             w_cy;
    logic [SEG:0][TAG_W-1:0]  w_tag;
    logic                     w_stall;
    logic                     w_unused_ops;

    // Only the output side can block; the whole pipe freezes together.
    assign w_stall  = w_vld[SEG] & ~out_ready;
    assign in_ready = ~w_stall;

    assign w_vld[0]  = in_valid;
    assign w_a[0]    = in_sum;
    assign w_b[0]    = in_carry;
    assign w_prod[0] = '0;
    assign w_cy[0]   = 1'b0;
    assign w_tag[0]  = in_tag;

    generate
        for (genvar k = 0; k < SEG; k++) begin : g_stage
            final_adder_stage #(
                .WIDTH  (WIDTH),
                .SW     (SW),
                .LO     (k * SW),
                .TAG_W  (TAG_W),
                .CY_REG ((k < SEG - 1) || OVF_EN)
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_stall(w_stall),
                .i_vld  (w_vld[k]),
                .i_a    (w_a[k]),
                .i_b    (w_b[k]),
                .i_prod (w_prod[k]),
                .i_cy   (w_cy[k]),
                .i_tag  (w_tag[k]),
                .o_vld  (w_vld[k+1]),
                .o_a    (w_a[k+1]),
                .o_b    (w_b[k+1]),
                .o_prod (w_prod[k+1]),
                .o_cy   (w_cy[k+1]),
                .o_tag  (w_tag[k+1])
            );
        end
    endgenerate

    // Operands forwarded out of the last stage have nothing left to feed.
    assign w_unused_ops = ^{w_a[SEG], w_b[SEG]};

    assign out_valid = w_vld[SEG];
    assign out_prod  = w_prod[SEG];
    assign out_tag   = w_tag[SEG];
    assign out_err   = w_cy[SEG];
endmodule
